// File: rtl/ebr_pkg.sv
// ebr_pkg: shared state encoding, default geometry and lane-count helper for the EBR RAM
package ebr_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH = 256;
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/ebr_ram_core.sv
// ebr_ram_core: inferred single-port array with byte-lane writes and read-first registered read
module ebr_ram_core import ebr_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int BE_W = be_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic in_range;
  assign idx = addr[IW-1:0];
  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  always_ff @(posedge clk_i) begin
    if (wr_en && in_range)
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
  // Out-of-range reads still strobe valid, returning zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= in_range ? mem[idx] : '0;
    end
  end
endmodule

// File: rtl/ebr_ram_clr.sv
// ebr_ram_clr: parametrised EBR RAM with byte enables, read-valid strobe and a clear sequencer
module ebr_ram_clr import ebr_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int CLEAR_ON_RST = 1,
  localparam int BE_W = be_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              wr_en_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic acc;
  assign busy_o = state == ST_CLEAR;
  assign acc = clk_en_i & ~busy_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR_ON_RST != 0 ? ST_CLEAR : ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= busy_o ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_nxt = busy_o ? (cnt == LAST ? ST_IDLE : ST_CLEAR) : (clr_i ? ST_CLEAR : ST_IDLE);
  end
  // Sequencer owns the port while busy; nothing is written during reset
  ebr_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (~rst_i & (busy_o | (acc & wr_en_i))),
    .rd_en   (acc & ~wr_en_i),
    .be      (busy_o ? {BE_W{1'b1}} : be_i),
    .addr    (busy_o ? cnt : addr_i),
    .wr_data (busy_o ? CLEAR_VAL : wr_data_i),
    .rd_data (rd_data_o),
    .rd_valid(rd_valid_o)
  );
endmodule

// File: tb/tb_ebr_ram_clr.sv
// tb_ebr_ram_clr: two configurations under shared random stimulus against an array-based model
module tb_ebr_ram_clr;
  logic clk = 1'b0;
  logic rst = 1'b1, clk_en = 1'b0, wr_en = 1'b0, clr = 1'b0;
  logic [1:0] be = '0;
  logic [7:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data [2];
  logic rd_valid [2];
  logic busy [2];
  int errors = 0, checks = 0;
  logic [15:0] mm [2][256];
  bit mk [2][256];
  int left [2], pos [2];
  logic [15:0] ed [2];
  bit edk [2], ev [2];

  always #5 clk = ~clk;

  ebr_ram_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .CLEAR_VAL(16'h0000), .CLEAR_ON_RST(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .wr_en_i(wr_en), .be_i(be), .addr_i(addr),
    .wr_data_i(wr_data), .clr_i(clr), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .busy_o(busy[0]));

  ebr_ram_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .CLEAR_VAL(16'hA5C3), .CLEAR_ON_RST(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .wr_en_i(wr_en), .be_i(be), .addr_i(addr),
    .wr_data_i(wr_data), .clr_i(clr), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .busy_o(busy[1]));

  function automatic int dep(input int i);
    return i == 0 ? 256 : 200;
  endfunction

  function automatic logic [15:0] cval(input int i);
    return i == 0 ? 16'h0000 : 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit bz, acc, inr;
    int a;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i] = i == 0 ? dep(i) : 0;
        pos[i] = 0;
        ev[i] = 0;
        ed[i] = '0;
        edk[i] = 1;
      end else begin
        bz = left[i] > 0;
        acc = clk_en && !bz;
        a = int'(addr);
        inr = a < dep(i);
        ev[i] = acc && !wr_en;
        if (ev[i]) begin
          ed[i] = inr ? mm[i][a] : 16'h0;
          edk[i] = inr ? mk[i][a] : 1'b1;
        end
        if (bz) begin
          mm[i][pos[i]] = cval(i);
          mk[i][pos[i]] = 1;
          pos[i]++;
          left[i]--;
        end else if (acc && wr_en && inr) begin
          for (int b = 0; b < 2; b++)
            if (be[b]) mm[i][a][8*b +: 8] = wr_data[8*b +: 8];
          mk[i][a] = mk[i][a] || (be == 2'b11);
        end
        if (!bz && clr) begin
          left[i] = dep(i);
          pos[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(left[i] > 0));
      check($sformatf("valid%0d", i), 32'(rd_valid[i]), 32'(ev[i]));
      if (edk[i]) check($sformatf("data%0d", i), 32'(rd_data[i]), 32'(ed[i]));
    end
  endtask

  task automatic access(input bit w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    clk_en = 1'b1;
    wr_en = w;
    addr = a;
    wr_data = d;
    be = b;
    tick();
    clk_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic randomize_inputs();
    clk_en = 1'($urandom_range(0, 1));
    wr_en = 1'($urandom_range(0, 1));
    be = 2'($urandom_range(0, 3));
    addr = 8'($urandom_range(0, 255));
    wr_data = 16'($urandom);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy[0] && n < 400) begin
      randomize_inputs();
      tick();
      n++;
    end
    clk_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid0", 32'(rd_valid[0]), 0);
    check("rst_data0", 32'(rd_data[0]), 0);
    check("rst_busy0", 32'(busy[0]), 1);
    check("rst_busy1", 32'(busy[1]), 0);
    rst = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_clear(n);
    check("busy_len", 32'(n), 32'd255);
    for (int a = 0; a < 256; a++) begin
      access(0, 8'(a), '0, '0);
      check("clr_rd", 32'(rd_data[0]), 0);
      check("clr_valid", 32'(rd_valid[0]), 1);
    end
    access(1, 8'h10, 16'hBEEF, 2'b11);
    access(1, 8'h10, 16'h1234, 2'b01);
    access(0, 8'h10, '0, '0);
    check("be_merge0", 32'(rd_data[0]), 32'h BE34);
    check("be_merge1", 32'(rd_data[1]), 32'h BE34);
    access(1, 8'h05, 16'h1111, 2'b11);
    access(1, 8'h05, 16'h2222, 2'b11);
    check("coll_novalid", 32'(rd_valid[0]), 0);
    check("coll_hold", 32'(rd_data[0]), 32'hBE34);
    access(0, 8'h05, '0, '0);
    check("coll_rd", 32'(rd_data[0]), 32'h2222);
    wr_en = 1'b1;
    addr = 8'h07;
    wr_data = 16'hDEAD;
    be = 2'b11;
    tick();
    check("noen_hold", 32'(rd_data[0]), 32'h2222);
    wr_en = 1'b0;
    access(0, 8'h07, '0, '0);
    check("noen_mem", 32'(rd_data[0]), 0);
    access(1, 8'd250, 16'h5A5A, 2'b11);
    access(0, 8'd250, '0, '0);
    check("oob_data", 32'(rd_data[1]), 0);
    check("oob_valid", 32'(rd_valid[1]), 1);
    check("inr_data", 32'(rd_data[0]), 32'h5A5A);
    clr = 1'b1;
    access(0, 8'h05, '0, '0);
    clr = 1'b0;
    check("clr_acc_valid", 32'(rd_valid[0]), 1);
    check("clr_acc_busy", 32'(busy[0]), 1);
    repeat (99) begin
      randomize_inputs();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n);
    check("busy_len_rst", 32'(n), 32'd256);
    for (int k = 0; k < 3000; k++) begin
      randomize_inputs();
      rst = $urandom_range(0, 499) == 0;
      clr = $urandom_range(0, 63) == 0;
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
